// File: rtl/axil_chk_pkg.sv
// Shared definitions for the AXI4-Lite write/readback checker.
//   state_t      : sweep FSM encoding
//   RESP_OKAY    : AXI response code treated as success
//   RESP_EXOKAY  : exclusive-okay code (counted as an error by this master)
//   pat()        : test pattern for a register index, SEED + idx*STEP (32-bit wrap)
package axil_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_CMP  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    function automatic logic [31:0] pat(input logic [31:0] seed,
                                        input logic [31:0] step,
                                        input logic [7:0]  idx);
        return seed + step * {24'd0, idx};
    endfunction

endpackage

// File: rtl/axil_chk_pattern.sv
// Combinational pattern generator: o_pat = pat(i_idx), zero-extended or
// truncated to DATA_WIDTH.
//   i_idx : register index
//   o_pat : pattern word for that index
module axil_chk_pattern
    import axil_chk_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'h0101FFFF,
    parameter logic [31:0] STEP       = 32'h9E3779B9
)(
    input  logic [7:0]            i_idx,
    output logic [DATA_WIDTH-1:0] o_pat
);

    assign o_pat = DATA_WIDTH'(pat(SEED, STEP, i_idx));

endmodule

// File: rtl/axil_wr_rd_checker.sv
// AXI4-Lite master that writes pat(idx) to NUM_REGS registers starting at
// BASE_ADDR (ADDR_STRIDE apart), reads each one back and counts write-response,
// read-response and data errors.
//   ACLK, ARESET         : clock, synchronous active-high reset
//   start                : pulse, honoured only in IDLE
//   busy                 : sweep in progress
//   done / pass          : one-cycle completion pulse / no errors seen
//   err_count            : saturating error count
//   first_fail_idx       : index of first error, 8'hFF when none
//   M_AXI_*              : AXI4-Lite master channels
// Build option AXIL_CHK_STOP_ON_ERR_EN: the first counted error ends the sweep.
//
// state | meaning
// IDLE  | waiting for start
// WR    | AW and W valid, each dropped on its own handshake
// WB    | waiting for write response
// RA    | AR valid at the same address
// RD    | waiting for read data
// CMP   | check captured response/data, advance or finish
// DONE  | one-cycle done/pass pulse
module axil_wr_rd_checker
    import axil_chk_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          ADDR_STRIDE = 4,
    parameter logic [31:0] SEED        = 32'h0101FFFF,
    parameter logic [31:0] STEP        = 32'h9E3779B9
)(
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               err_count,
    output logic [7:0]                first_fail_idx,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

    state_t                  r_state;
    logic [7:0]              r_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                    r_busy, r_done, r_pass;
    logic [15:0]             r_err_count;
    logic [7:0]              r_first_fail;

    logic [7:0]              w_pat_idx;
    logic [DATA_WIDTH-1:0]   w_pat;
    logic                    w_b_err, w_r_err, w_err, w_first_err, w_stop, w_wr_done;
    logic [15:0]             w_err_next;

    // Pattern for the index about to be written: 0 on start, idx+1 when advancing.
    assign w_pat_idx = (r_state == ST_IDLE) ? 8'd0 : r_idx + 8'd1;

    axil_chk_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED),
        .STEP       (STEP)
    ) u_pattern (
        .i_idx (w_pat_idx),
        .o_pat (w_pat)
    );

    // WDATA is held for the whole index, so it doubles as the expected readback.
    assign w_b_err     = (r_state == ST_WB) && M_AXI_BVALID && (M_AXI_BRESP != RESP_OKAY);
    assign w_r_err     = (r_state == ST_CMP) && ((r_rresp != RESP_OKAY) || (r_rdata != r_wdata));
    assign w_err       = w_b_err || w_r_err;
    assign w_first_err = w_err && (r_err_count == 16'd0);
    assign w_err_next  = (w_err && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1 : r_err_count;
    assign w_wr_done   = (!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY);

`ifdef AXIL_CHK_STOP_ON_ERR_EN
    assign w_stop = w_err;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= ST_IDLE;
            r_idx        <= 8'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 16'd0;
            r_first_fail <= 8'hFF;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err_count  <= 16'd0;
                        r_first_fail <= 8'hFF;
                        r_idx        <= 8'd0;
                        r_addr       <= ADDR_WIDTH'(BASE_ADDR);
                        r_wdata      <= w_pat;
                        r_awvalid    <= 1'b1;
                        r_wvalid     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_awvalid <= r_awvalid && !M_AXI_AWREADY;
                    r_wvalid  <= r_wvalid && !M_AXI_WREADY;
                    if (w_wr_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_err_count <= w_err_next;
                        if (w_first_err) r_first_fail <= r_idx;
                        if (w_stop) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 16'd0);
                            r_state <= ST_DONE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RA;
                        end
                    end
                end
                ST_RA: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        r_rdata  <= M_AXI_RDATA;
                        r_rresp  <= M_AXI_RRESP;
                        r_state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_err_count <= w_err_next;
                    if (w_first_err) r_first_fail <= r_idx;
                    if (w_stop || (r_idx == LAST_IDX)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 16'd0);
                        r_state <= ST_DONE;
                    end else begin
                        r_idx     <= r_idx + 8'd1;
                        r_addr    <= r_addr + ADDR_WIDTH'(ADDR_STRIDE);
                        r_wdata   <= w_pat;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_WR;
                    end
                end
                ST_DONE: begin
                    r_pass  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_fail_idx = r_first_fail;
    assign M_AXI_AWADDR   = r_addr;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWVALID  = r_awvalid;
    assign M_AXI_WDATA    = r_wdata;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WVALID   = r_wvalid;
    assign M_AXI_BREADY   = r_bready;
    assign M_AXI_ARADDR   = r_addr;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARVALID  = r_arvalid;
    assign M_AXI_RREADY   = r_rready;

endmodule

// File: tb/tb_axil_wr_rd_checker.sv
// Bench for axil_wr_rd_checker: a 4-register sweep at 0x43C00000 against a
// behavioural slave (zero-wait or random-delay, with fault injection), plus a
// single-register instance against a trivial zero-wait slave.
// Expectations follow AXIL_CHK_STOP_ON_ERR_EN when the bench is built with it.
module tb_axil_wr_rd_checker;

    logic        aclk = 1'b0;
    logic        rst  = 1'b1;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT 1: NUM_REGS=4, BASE 0x43C00000 ----------------
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [7:0]  ffi;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axil_wr_rd_checker #(.NUM_REGS(4), .BASE_ADDR(32'h43C00000)) dut (
        .ACLK(aclk), .ARESET(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_fail_idx(ffi),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // ---------------- DUT 2: NUM_REGS=1, defaults otherwise ----------------
    logic        start_2 = 1'b0;
    logic        busy_2, done_2, pass_2;
    logic [15:0] err_count_2;
    logic [7:0]  ffi_2;
    logic [31:0] awaddr_2, wdata_2, araddr_2;
    logic [31:0] rdata_2 = 32'd0;
    logic [2:0]  awprot_2, arprot_2;
    logic [3:0]  wstrb_2;
    logic        awvalid_2, wvalid_2, bready_2, arvalid_2, rready_2;
    logic        bvalid_2 = 1'b0;
    logic        rvalid_2 = 1'b0;
    logic        ready_2 = 1'b1;
    logic [1:0]  resp_2 = 2'b00;

    axil_wr_rd_checker #(.NUM_REGS(1)) dut_2 (
        .ACLK(aclk), .ARESET(rst), .start(start_2), .busy(busy_2), .done(done_2),
        .pass(pass_2), .err_count(err_count_2), .first_fail_idx(ffi_2),
        .M_AXI_AWADDR(awaddr_2), .M_AXI_AWPROT(awprot_2), .M_AXI_AWVALID(awvalid_2),
        .M_AXI_AWREADY(ready_2), .M_AXI_WDATA(wdata_2), .M_AXI_WSTRB(wstrb_2),
        .M_AXI_WVALID(wvalid_2), .M_AXI_WREADY(ready_2), .M_AXI_BRESP(resp_2),
        .M_AXI_BVALID(bvalid_2), .M_AXI_BREADY(bready_2), .M_AXI_ARADDR(araddr_2),
        .M_AXI_ARPROT(arprot_2), .M_AXI_ARVALID(arvalid_2), .M_AXI_ARREADY(ready_2),
        .M_AXI_RDATA(rdata_2), .M_AXI_RRESP(resp_2), .M_AXI_RVALID(rvalid_2),
        .M_AXI_RREADY(rready_2)
    );

    logic [31:0] mem_2 = 32'd0;
    logic [31:0] awaddr_log_2 = 32'hFFFFFFFF;
    int          wcnt_2 = 0;

    always @(posedge aclk) begin
        if (rst) begin
            bvalid_2 <= 1'b0;
            rvalid_2 <= 1'b0;
            wcnt_2 = 0;
        end else begin
            if (bvalid_2 && bready_2) bvalid_2 <= 1'b0;
            if (rvalid_2 && rready_2) rvalid_2 <= 1'b0;
            if (awvalid_2 && wvalid_2) begin
                mem_2 = wdata_2;
                awaddr_log_2 = awaddr_2;
                wcnt_2++;
                bvalid_2 <= 1'b1;
            end
            if (arvalid_2) begin
                rvalid_2 <= 1'b1;
                rdata_2  <= mem_2;
            end
        end
    end

    // ---------------- Behavioural slave for DUT 1 ----------------
    logic        fast = 1'b1;
    int          bad_bresp_idx = -1;
    int          stuck_idx = -1;
    logic [31:0] mem [0:7];
    logic [31:0] wr_log [0:15];
    logic [31:0] wr_addr_log [0:15];
    logic [31:0] s_awaddr, s_wdata, s_araddr, rd_tmp;
    logic [1:0]  b_resp_n;
    logic        aw_got, w_got, b_pend, r_pend;
    int          wr_cnt, ar_cnt, r_idx_cur;
    int          dly_aw, dly_w, dly_b, dly_ar, dly_r;
    int          cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r;

    task automatic pick_delays();
        if (fast) begin
            dly_aw = 0; dly_w = 0; dly_b = 0; dly_ar = 0; dly_r = 0;
        end else begin
            dly_aw = int'($urandom_range(0, 5));
            dly_w  = dly_aw + 3;
            dly_b  = int'($urandom_range(0, 5));
            dly_ar = int'($urandom_range(0, 5));
            dly_r  = int'($urandom_range(0, 5));
        end
        cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_ar = 0; cnt_r = 0;
    endtask

    always @(posedge aclk) begin
        if (rst) begin
            awready <= fast; wready <= fast; arready <= fast;
            bvalid  <= 1'b0; rvalid <= 1'b0;
            bresp   <= 2'b00; rresp <= 2'b00; rdata <= 32'd0;
            aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            wr_cnt = 0; ar_cnt = 0; r_idx_cur = 0; b_resp_n = 2'b00;
            pick_delays();
        end else begin
            if (awvalid && awready) begin
                aw_got = 1'b1; s_awaddr = awaddr;
                if (!fast) awready <= 1'b0;
            end else if (!fast && awvalid && !awready && !aw_got) begin
                if (cnt_aw >= dly_aw) awready <= 1'b1; else cnt_aw++;
            end
            if (wvalid && wready) begin
                w_got = 1'b1; s_wdata = wdata;
                if (!fast) wready <= 1'b0;
            end else if (!fast && wvalid && !wready && !w_got) begin
                if (cnt_w >= dly_w) wready <= 1'b1; else cnt_w++;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                pick_delays();
            end
            if (aw_got && w_got && !b_pend) begin
                mem[s_awaddr[4:2]] = s_wdata;
                if (wr_cnt < 16) begin
                    wr_log[wr_cnt] = s_wdata;
                    wr_addr_log[wr_cnt] = s_awaddr;
                end
                b_resp_n = (wr_cnt == bad_bresp_idx) ? 2'b10 : 2'b00;
                wr_cnt++;
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
            end
            if (b_pend) begin
                if (cnt_b >= dly_b) begin
                    bvalid <= 1'b1; bresp <= b_resp_n; b_pend = 1'b0;
                end else cnt_b++;
            end
            if (arvalid && arready) begin
                s_araddr = araddr; r_idx_cur = ar_cnt; ar_cnt++;
                r_pend = 1'b1; cnt_r = 0;
                if (!fast) arready <= 1'b0;
            end else if (!fast && arvalid && !arready && !r_pend) begin
                if (cnt_ar >= dly_ar) arready <= 1'b1; else cnt_ar++;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (r_pend) begin
                if (cnt_r >= dly_r) begin
                    rd_tmp = mem[s_araddr[4:2]];
                    if (r_idx_cur == stuck_idx) rd_tmp[0] = 1'b0;
                    rvalid <= 1'b1; rdata <= rd_tmp; rresp <= 2'b00; r_pend = 1'b0;
                end else cnt_r++;
            end
        end
    end

    // VALID must stay high with stable payload until its READY.
    int          viol = 0;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(negedge aclk) begin
        if (rst) begin
            p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
        end else begin
            if (p_aw && (awvalid !== 1'b1 || awaddr !== p_awaddr)) viol++;
            if (p_w  && (wvalid  !== 1'b1 || wdata  !== p_wdata))  viol++;
            if (p_ar && (arvalid !== 1'b1 || araddr !== p_araddr)) viol++;
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid  && !wready;  p_wdata  = wdata;
            p_ar = arvalid && !arready; p_araddr = araddr;
        end
    end

    // ---------------- Stimulus helpers ----------------
    logic [31:0] exp_pat [0:3];
    logic        c1_busy, c1_awv, c1_wv;
    logic [31:0] c1_awaddr;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;
    endtask

    task automatic run_sweep(output int cyc, output logic [15:0] e,
                             output logic [7:0] f, output logic p);
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge aclk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                c1_busy = busy; c1_awv = awvalid; c1_wv = wvalid; c1_awaddr = awaddr;
            end
        end while (done !== 1'b1 && cyc < 3000);
        e = err_count; f = ffi; p = pass;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL sweep_timeout: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        fast = 1'b1;
        do_reset();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b pass=%b, required 0 0 0", busy, done, pass); end
        checks++; if (err_count !== 16'd0) begin
            errors++; $display("FAIL reset_err_count: got %h, required 0000", err_count); end
        checks++; if (ffi !== 8'hFF) begin
            errors++; $display("FAIL reset_first_fail: got %h, required ff", ffi); end
        checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi: aw w b ar r = %b, required 00000",
                               {awvalid, wvalid, bready, arvalid, rready}); end
    endtask

    task automatic test_zero_wait();
        int cyc; logic [15:0] e; logic [7:0] f; logic p;
        fast = 1'b1; bad_bresp_idx = -1; stuck_idx = -1;
        do_reset();
        run_sweep(cyc, e, f, p);
        checks++; if (c1_busy !== 1'b1 || c1_awv !== 1'b1 || c1_wv !== 1'b1) begin
            errors++; $display("FAIL zw_cycle1: busy/awvalid/wvalid=%b%b%b, required 111", c1_busy, c1_awv, c1_wv); end
        checks++; if (c1_awaddr !== 32'h43C00000) begin
            errors++; $display("FAIL zw_first_addr: got %h, required 43c00000", c1_awaddr); end
        checks++; if (cyc != 21) begin
            errors++; $display("FAIL zw_done_cycle: got %0d, required 21", cyc); end
        checks++; if (p !== 1'b1 || e !== 16'd0 || f !== 8'hFF) begin
            errors++; $display("FAIL zw_result: pass=%b err=%h ffi=%h, required 1 0000 ff", p, e, f); end
        checks++; if (wstrb !== 4'hF || awprot !== 3'd0 || arprot !== 3'd0) begin
            errors++; $display("FAIL zw_strb_prot: wstrb=%h awprot=%0d arprot=%0d, required f 0 0", wstrb, awprot, arprot); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_log[i] !== exp_pat[i] || wr_addr_log[i] !== 32'h43C00000 + 32'(4 * i)) begin
                errors++; $display("FAIL zw_write%0d: data %h addr %h, required %h %h", i,
                                   wr_log[i], wr_addr_log[i], exp_pat[i], 32'h43C00000 + 32'(4 * i)); end
        end
        checks++; if (wr_cnt != 4 || ar_cnt != 4) begin
            errors++; $display("FAIL zw_counts: writes %0d reads %0d, required 4 4", wr_cnt, ar_cnt); end
        @(posedge aclk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL zw_after_done: done=%b busy=%b pass=%b, required 0 0 0", done, busy, pass); end
    endtask

    task automatic test_random_delay();
        int cyc; logic [15:0] e; logic [7:0] f; logic p;
        fast = 1'b0; bad_bresp_idx = -1; stuck_idx = -1;
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        do_reset();
        viol = 0;
        run_sweep(cyc, e, f, p);
        checks++; if (p !== 1'b1 || e !== 16'd0 || f !== 8'hFF) begin
            errors++; $display("FAIL rd_result: pass=%b err=%h ffi=%h, required 1 0000 ff", p, e, f); end
        checks++; if (viol != 0) begin
            errors++; $display("FAIL rd_valid_hold: %0d early drops, required 0", viol); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_log[i] !== exp_pat[i]) begin
                errors++; $display("FAIL rd_write%0d: got %h, required %h", i, wr_log[i], exp_pat[i]); end
        end
        checks++; if (cyc <= 21) begin
            errors++; $display("FAIL rd_slowdown: done at %0d, required > 21", cyc); end
        fast = 1'b1;
    endtask

    task automatic test_stuck_bit();
        int cyc; logic [15:0] e; logic [7:0] f; logic p; int exp_ar, exp_cyc;
`ifdef AXIL_CHK_STOP_ON_ERR_EN
        exp_ar = 3; exp_cyc = 16;
`else
        exp_ar = 4; exp_cyc = 21;
`endif
        fast = 1'b1; bad_bresp_idx = -1; stuck_idx = 2;
        do_reset();
        run_sweep(cyc, e, f, p);
        checks++; if (e !== 16'd1 || f !== 8'd2 || p !== 1'b0) begin
            errors++; $display("FAIL stuck_result: err=%h ffi=%h pass=%b, required 0001 02 0", e, f, p); end
        checks++; if (ar_cnt != exp_ar || cyc != exp_cyc) begin
            errors++; $display("FAIL stuck_extent: reads %0d done %0d, required %0d %0d", ar_cnt, cyc, exp_ar, exp_cyc); end
        stuck_idx = -1;
    endtask

    task automatic test_bresp_err();
        int cyc; logic [15:0] e; logic [7:0] f; logic p; int exp_ar, exp_wr, exp_cyc;
`ifdef AXIL_CHK_STOP_ON_ERR_EN
        exp_ar = 1; exp_wr = 2; exp_cyc = 8;
`else
        exp_ar = 4; exp_wr = 4; exp_cyc = 21;
`endif
        fast = 1'b1; bad_bresp_idx = 1; stuck_idx = -1;
        do_reset();
        run_sweep(cyc, e, f, p);
        checks++; if (e !== 16'd1 || f !== 8'd1 || p !== 1'b0) begin
            errors++; $display("FAIL bresp_result: err=%h ffi=%h pass=%b, required 0001 01 0", e, f, p); end
        checks++; if (ar_cnt != exp_ar || wr_cnt != exp_wr || cyc != exp_cyc) begin
            errors++; $display("FAIL bresp_extent: reads %0d writes %0d done %0d, required %0d %0d %0d",
                               ar_cnt, wr_cnt, cyc, exp_ar, exp_wr, exp_cyc); end
        bad_bresp_idx = -1;
    endtask

    task automatic test_reset_mid_read();
        int cyc; logic [15:0] e; logic [7:0] f; logic p;
        fast = 1'b1;
        do_reset();
        start = 1'b1; cyc = 0;
        do begin
            @(posedge aclk); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
        end while (ar_cnt < 4 && cyc < 200);
        checks++; if (ar_cnt != 4 || rready !== 1'b1) begin
            errors++; $display("FAIL mid_reach_rd: reads %0d rready %b, required 4 1", ar_cnt, rready); end
        rst = 1'b1;
        @(posedge aclk); #1;
        checks++; if ({busy, done, pass, awvalid, wvalid, bready, arvalid, rready} !== 8'd0
                      || err_count !== 16'd0 || ffi !== 8'hFF) begin
            errors++; $display("FAIL mid_reset_values: flags %b err %h ffi %h, required 00000000 0000 ff",
                               {busy, done, pass, awvalid, wvalid, bready, arvalid, rready}, err_count, ffi); end
        rst = 1'b0;
        @(posedge aclk); #1;
        run_sweep(cyc, e, f, p);
        checks++; if (c1_awaddr !== 32'h43C00000 || cyc != 21 || p !== 1'b1) begin
            errors++; $display("FAIL mid_restart: addr %h done %0d pass %b, required 43c00000 21 1", c1_awaddr, cyc, p); end
    endtask

    task automatic test_back_to_back_start();
        int cyc;
        do_reset();
        start_2 = 1'b1; cyc = 0;
        do begin
            @(posedge aclk); #1;
            cyc++;
            start_2 = (cyc == 2);
        end while (done_2 !== 1'b1 && cyc < 100);
        checks++; if (cyc != 6) begin
            errors++; $display("FAIL single_done_cycle: got %0d, required 6", cyc); end
        checks++; if (pass_2 !== 1'b1 || err_count_2 !== 16'd0 || ffi_2 !== 8'hFF) begin
            errors++; $display("FAIL single_result: pass=%b err=%h ffi=%h, required 1 0000 ff", pass_2, err_count_2, ffi_2); end
        start_2 = 1'b1;
        @(posedge aclk); #1;
        start_2 = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        checks++; if (busy_2 !== 1'b0 || wcnt_2 != 1) begin
            errors++; $display("FAIL single_ignored_start: busy=%b writes=%0d, required 0 1", busy_2, wcnt_2); end
        checks++; if (mem_2 !== 32'h0101FFFF || awaddr_log_2 !== 32'h0) begin
            errors++; $display("FAIL single_write: data %h addr %h, required 0101ffff 00000000", mem_2, awaddr_log_2); end
    endtask

    initial begin
        exp_pat[0] = 32'h0101FFFF;
        exp_pat[1] = 32'h9F3979B8;
        exp_pat[2] = 32'h3D70F371;
        exp_pat[3] = 32'hDBA86D2A;
        test_reset();
        test_zero_wait();
        test_random_delay();
        test_stuck_bit();
        test_bresp_err();
        test_reset_mid_read();
        test_back_to_back_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
